// File: rtl/rifl_tx_replay_sched.sv
// +----------------------------------------------------------------------------+
// | rifl_tx_replay_sched: per-slot TX frame arbiter with rollback replay.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rifl_tx_replay_sched #(
  parameter int FRAME_ID_WIDTH  = 8,
  parameter int ROLLBACK_CYCLES = 16,
  parameter int HOLDOFF_SLOTS   = 32,
  parameter int ADDR_WIDTH      = $clog2(ROLLBACK_CYCLES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_tx_up,
  input  logic                      i_slot,
  input  logic                      i_user_valid,
  output logic                      o_user_ready,
  input  logic                      i_ctrl_req,
  output logic                      o_ctrl_ack,
  input  logic                      i_remote_error,
  output logic                      o_frame_valid,
  output logic [1:0]                o_frame_type,
  output logic [FRAME_ID_WIDTH-1:0] o_frame_id,
  output logic                      o_frame_src,
  output logic                      o_buf_wr_en,
  output logic [ADDR_WIDTH-1:0]     o_buf_wr_addr,
  output logic                      o_buf_rd_en,
  output logic [ADDR_WIDTH-1:0]     o_buf_rd_addr,
  output logic                      o_replaying
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int HW = $clog2(HOLDOFF_SLOTS + 1);

  localparam logic [1:0]                c_TYPE_IDLE = 2'b00;
  localparam logic [1:0]                c_TYPE_DATA = 2'b01;
  localparam logic [1:0]                c_TYPE_CTRL = 2'b10;
  localparam logic [FRAME_ID_WIDTH-1:0] c_ROLLBACK  = FRAME_ID_WIDTH'(ROLLBACK_CYCLES);
  localparam logic [CW-1:0]             c_RP_CNT    = CW'(ROLLBACK_CYCLES);
  localparam logic [HW-1:0]             c_HOLDOFF   = HW'(HOLDOFF_SLOTS);

  typedef enum logic [1:0] {
    S_DOWN   = 2'd0,
    S_NORMAL = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

  state_t                    r_state;
  logic [FRAME_ID_WIDTH-1:0] r_tx_id;
  logic [FRAME_ID_WIDTH-1:0] r_rp_id;
  logic [CW-1:0]             r_rp_cnt;
  logic [HW-1:0]             r_holdoff;
  logic                      r_err_d;

  logic                      w_decide;
  logic                      w_data_new;
  logic                      w_data_rp;
  logic                      w_rp_last;
  logic                      w_trig;
  logic [FRAME_ID_WIDTH-1:0] w_tx_id_nxt;

  assign w_decide     = i_slot & i_tx_up & (r_state != S_DOWN);
  assign o_user_ready = i_slot & i_tx_up & (r_state == S_NORMAL) & ~i_ctrl_req;
  assign o_ctrl_ack   = w_decide & i_ctrl_req;
  assign w_data_new   = o_user_ready & i_user_valid;
  assign w_data_rp    = w_decide & ~i_ctrl_req & (r_state == S_REPLAY);
  assign w_rp_last    = w_data_rp & (r_rp_cnt == CW'(1));
  assign w_tx_id_nxt  = r_tx_id + (w_data_new ? FRAME_ID_WIDTH'(1) : FRAME_ID_WIDTH'(0));

  // A fresh edge always triggers; a level still high only after holdoff expires.
  assign w_trig = i_tx_up & (r_state == S_NORMAL) & i_remote_error &
                  (~r_err_d | (r_holdoff == HW'(0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_DOWN;
      r_tx_id       <= '0;
      r_rp_id       <= '0;
      r_rp_cnt      <= '0;
      r_holdoff     <= '0;
      r_err_d       <= 1'b0;
      o_frame_valid <= 1'b0;
      o_frame_type  <= c_TYPE_IDLE;
      o_frame_id    <= '0;
      o_frame_src   <= 1'b0;
      o_buf_wr_en   <= 1'b0;
      o_buf_wr_addr <= '0;
      o_buf_rd_en   <= 1'b0;
      o_buf_rd_addr <= '0;
      o_replaying   <= 1'b0;
    end else begin
      r_err_d       <= i_remote_error;
      o_frame_valid <= 1'b0;
      o_buf_wr_en   <= 1'b0;
      o_buf_rd_en   <= 1'b0;

      if (i_slot && (r_holdoff != HW'(0))) begin
        r_holdoff <= r_holdoff - HW'(1);
      end

      if (w_decide) begin
        o_frame_valid <= 1'b1;
        o_frame_id    <= r_tx_id;
        o_frame_src   <= 1'b0;
        if (i_ctrl_req) begin
          o_frame_type <= c_TYPE_CTRL;
        end else if (r_state == S_REPLAY) begin
          o_frame_type  <= c_TYPE_DATA;
          o_frame_id    <= r_rp_id;
          o_frame_src   <= 1'b1;
          o_buf_rd_en   <= 1'b1;
          o_buf_rd_addr <= r_rp_id[ADDR_WIDTH-1:0];
        end else if (i_user_valid) begin
          o_frame_type  <= c_TYPE_DATA;
          o_buf_wr_en   <= 1'b1;
          o_buf_wr_addr <= r_tx_id[ADDR_WIDTH-1:0];
        end else begin
          o_frame_type <= c_TYPE_IDLE;
        end
      end

      r_tx_id <= w_tx_id_nxt;

      if (w_data_rp) begin
        r_rp_id  <= r_rp_id + FRAME_ID_WIDTH'(1);
        r_rp_cnt <= r_rp_cnt - CW'(1);
      end

      case (r_state)
        S_DOWN: begin
          if (i_tx_up) r_state <= S_NORMAL;
        end
        S_NORMAL: begin
          if (w_trig) begin
            // Rewind from the id after this cycle's decision so the last replayed id is tx_id-1.
            r_rp_id     <= w_tx_id_nxt - c_ROLLBACK;
            r_rp_cnt    <= c_RP_CNT;
            r_state     <= S_REPLAY;
            o_replaying <= 1'b1;
          end
        end
        S_REPLAY: begin
          if (w_rp_last) begin
            r_state     <= S_NORMAL;
            r_holdoff   <= c_HOLDOFF;
            o_replaying <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_DOWN;
          o_replaying <= 1'b0;
        end
      endcase

      if (!i_tx_up) begin
        r_state     <= S_DOWN;
        r_rp_cnt    <= '0;
        o_replaying <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rifl_tx_replay_sched.sv
// +----------------------------------------------------------------------------+
// | tb_rifl_tx_replay_sched: table vectors plus scoreboarded replay sequences. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rifl_tx_replay_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tx_up, i_slot, i_user_valid, i_ctrl_req, i_remote_error;
  logic       o_user_ready, o_ctrl_ack, o_frame_valid, o_frame_src;
  logic       o_buf_wr_en, o_buf_rd_en, o_replaying;
  logic [1:0] o_frame_type;
  logic [7:0] o_frame_id;
  logic [3:0] o_buf_wr_addr, o_buf_rd_addr;

  always #5 clk = ~clk;

  rifl_tx_replay_sched dut (
    .clk            (clk),
    .rst            (rst),
    .i_tx_up        (i_tx_up),
    .i_slot         (i_slot),
    .i_user_valid   (i_user_valid),
    .o_user_ready   (o_user_ready),
    .i_ctrl_req     (i_ctrl_req),
    .o_ctrl_ack     (o_ctrl_ack),
    .i_remote_error (i_remote_error),
    .o_frame_valid  (o_frame_valid),
    .o_frame_type   (o_frame_type),
    .o_frame_id     (o_frame_id),
    .o_frame_src    (o_frame_src),
    .o_buf_wr_en    (o_buf_wr_en),
    .o_buf_wr_addr  (o_buf_wr_addr),
    .o_buf_rd_en    (o_buf_rd_en),
    .o_buf_rd_addr  (o_buf_rd_addr),
    .o_replaying    (o_replaying)
  );

  typedef struct {
    logic [1:0] typ;
    logic [7:0] id;
    logic       src;
    logic       wr;
    logic       rd;
    logic [3:0] wa;
    logic [3:0] ra;
  } exp_t;

  typedef struct {
    bit         ctrl;
    bit         user;
    logic [1:0] typ;
    logic [7:0] id;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: 0 down, 1 normal, 2 replay
  int         m_st;
  logic [7:0] m_tx;
  logic [7:0] m_rp;
  int         m_cnt;
  int         m_hold;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (o_frame_valid === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_unexpected: got type=%0d id=%0d, required no frame (t=%0t)",
                 o_frame_type, o_frame_id, $time);
      end else begin
        mon_e = q.pop_front();
        if (o_frame_type !== mon_e.typ || o_frame_id !== mon_e.id || o_frame_src !== mon_e.src ||
            o_buf_wr_en !== mon_e.wr || o_buf_rd_en !== mon_e.rd ||
            (mon_e.wr && o_buf_wr_addr !== mon_e.wa) || (mon_e.rd && o_buf_rd_addr !== mon_e.ra)) begin
          n_fail++;
          $display("FAIL frame: got type=%0d id=%0d src=%0d wr=%0d wa=%0d rd=%0d ra=%0d, required type=%0d id=%0d src=%0d wr=%0d wa=%0d rd=%0d ra=%0d (t=%0t)",
                   o_frame_type, o_frame_id, o_frame_src, o_buf_wr_en, o_buf_wr_addr, o_buf_rd_en, o_buf_rd_addr,
                   mon_e.typ, mon_e.id, mon_e.src, mon_e.wr, mon_e.wa, mon_e.rd, mon_e.ra, $time);
        end
      end
    end
  end

  task automatic enter_replay();
    m_rp  = m_tx - 8'd16;
    m_cnt = 16;
    m_st  = 2;
  endtask

  task automatic do_slot(input bit ctrl, input bit user, input bit use_tbl = 1'b0,
                         input logic [1:0] t_typ = 2'b00, input logic [7:0] t_id = 8'd0);
    exp_t e;
    bit   push, x_ready, x_ack, x_rep, ended;
    @(posedge clk); #1;
    i_slot = 1'b1; i_ctrl_req = ctrl; i_user_valid = user;
    x_ready = (m_st == 1) && !ctrl;
    x_ack   = (m_st != 0) && ctrl;
    x_rep   = (m_st == 2);
    push    = (m_st != 0);
    ended   = 1'b0;
    e.typ = 2'b00; e.id = m_tx; e.src = 1'b0; e.wr = 1'b0; e.rd = 1'b0; e.wa = 4'd0; e.ra = 4'd0;
    if (m_st != 0) begin
      if (ctrl) begin
        e.typ = 2'b10;
      end else if (m_st == 2) begin
        e.typ = 2'b01; e.id = m_rp; e.src = 1'b1; e.rd = 1'b1; e.ra = m_rp[3:0];
        m_rp  = m_rp + 8'd1;
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_st = 1; ended = 1'b1; end
      end else if (user) begin
        e.typ = 2'b01; e.wr = 1'b1; e.wa = m_tx[3:0];
        m_tx  = m_tx + 8'd1;
      end
    end
    if (m_hold > 0) m_hold--;
    if (ended) m_hold = 32;
    if (use_tbl) begin e.typ = t_typ; e.id = t_id; end
    @(negedge clk);
    chk("user_ready", {31'd0, o_user_ready}, {31'd0, x_ready});
    chk("ctrl_ack",   {31'd0, o_ctrl_ack},   {31'd0, x_ack});
    chk("replaying",  {31'd0, o_replaying},  {31'd0, x_rep});
    if (push) q.push_back(e);
    @(posedge clk); #1;
    i_slot = 1'b0; i_ctrl_req = 1'b0; i_user_valid = 1'b0;
    @(negedge clk); #1;
    chk("frame_missing", q.size(), 0);
    q.delete();
    if (i_remote_error && m_st == 1 && m_hold == 0) enter_replay();
  endtask

  task automatic raise_err();
    @(posedge clk); #1;
    i_remote_error = 1'b1;
    if (m_st == 1) enter_replay();
  endtask

  task automatic drop_err();
    @(posedge clk); #1;
    i_remote_error = 1'b0;
  endtask

  task automatic model_reset();
    m_st = 0; m_tx = 8'd0; m_rp = 8'd0; m_cnt = 0; m_hold = 0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},     {31'd0, o_frame_valid}, 32'd0);
    chk({tag, "_type"},      {30'd0, o_frame_type},  32'd0);
    chk({tag, "_id"},        {24'd0, o_frame_id},    32'd0);
    chk({tag, "_src"},       {31'd0, o_frame_src},   32'd0);
    chk({tag, "_wr_en"},     {31'd0, o_buf_wr_en},   32'd0);
    chk({tag, "_rd_en"},     {31'd0, o_buf_rd_en},   32'd0);
    chk({tag, "_replaying"}, {31'd0, o_replaying},   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{ctrl: 1'b0, user: 1'b1, typ: 2'b01, id: 8'd0};
    tbl[1] = '{ctrl: 1'b0, user: 1'b1, typ: 2'b01, id: 8'd1};
    tbl[2] = '{ctrl: 1'b0, user: 1'b1, typ: 2'b01, id: 8'd2};
    tbl[3] = '{ctrl: 1'b1, user: 1'b1, typ: 2'b10, id: 8'd3};
    tbl[4] = '{ctrl: 1'b0, user: 1'b1, typ: 2'b01, id: 8'd3};

    rst = 1'b1; i_tx_up = 1'b0; i_slot = 1'b0; i_user_valid = 1'b0;
    i_ctrl_req = 1'b0; i_remote_error = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("reset");

    do_slot(1'b0, 1'b1);                     // DOWN: no decision
    @(posedge clk); #1 i_tx_up = 1'b1; m_st = 1;

    for (int i = 0; i < 5; i++) do_slot(tbl[i].ctrl, tbl[i].user, 1'b1, tbl[i].typ, tbl[i].id);

    for (int i = 0; i < 16; i++) do_slot(1'b0, 1'b1);
    do_slot(1'b0, 1'b0);                     // idle at tx_id 20
    chk("tx_id_before_replay", {24'd0, m_tx}, 32'd20);

    raise_err();
    for (int i = 0; i < 17; i++) do_slot(i == 8, 1'b1);
    for (int i = 0; i < 32; i++) do_slot(1'b0, 1'b1);
    chk("holdoff_retrigger_start", {24'd0, m_rp}, 32'd36);
    for (int i = 0; i < 16; i++) do_slot(1'b0, 1'b1);
    drop_err();
    do_slot(1'b0, 1'b1);

    // Wrap case: rewind from tx_id 5
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset(); m_st = 1;
    for (int i = 0; i < 5; i++) do_slot(1'b0, 1'b1);
    raise_err();
    chk("wrap_start", {24'd0, m_rp}, 32'd245);
    drop_err();
    for (int i = 0; i < 16; i++) do_slot(1'b0, 1'b1);

    // Reset on the 7th replay slot
    raise_err();
    drop_err();
    for (int i = 0; i < 6; i++) do_slot(1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; i_slot = 1'b1; i_user_valid = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk_zero_outputs("mid_replay_rst");
    chk("rst_down_ready", {31'd0, o_user_ready}, 32'd0);
    @(posedge clk); #1 i_slot = 1'b0; i_user_valid = 1'b0;
    @(negedge clk);
    chk("rst_down_no_frame", {31'd0, o_frame_valid}, 32'd0);
    m_st = 1;
    do_slot(1'b0, 1'b1);                     // tx_id restarts at 0

    // Link drop mid-replay
    for (int i = 0; i < 3; i++) do_slot(1'b0, 1'b1);
    raise_err();
    drop_err();
    for (int i = 0; i < 3; i++) do_slot(1'b0, 1'b1);
    @(posedge clk); #1 i_tx_up = 1'b0; m_st = 0; m_cnt = 0;
    do_slot(1'b0, 1'b1);
    @(posedge clk); #1 i_tx_up = 1'b1; m_st = 1;
    do_slot(1'b0, 1'b1);
    do_slot(1'b0, 1'b1);
    chk("tx_id_after_link_drop", {24'd0, m_tx}, 32'd6);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
